fft_in_loader: RTL and testbench

- Upstream stage of the 64-entry x 38-bit FFT input buffer.
- Accepts a valid/ready sample stream: 38-bit words, I in [37:19] and Q in [18:0].
- Frames every 64 samples and writes them into the buffer in bit-reversed address order.
- Once the frame is complete, hands the buffer to the FFT core for reading, then reclaims it when the core acknowledges.

---
 rtl/fft_in_loader.sv | 109 ++++++++++
 tb/tb_fft_in_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_in_loader.sv
// Frames a valid/ready sample stream into the 64-entry FFT input buffer (bit-reversed writes),
// then hands the buffer to the FFT core until it acknowledges.
module fft_in_loader #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 38,
  parameter int BITREV = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sof,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] fft_rd_addr,
  input  logic              fft_ack,
  output logic              frame_rdy,
  output logic              regfft_wren,
  output logic [ADDR_W-1:0] regfft_addr,
  output logic [DATA_W-1:0] regfft_data,
  output logic [7:0]        frame_cnt,
  output logic              sync_err,
  input  logic              err_clr
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FULL} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic                r_wren;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic                r_frame_rdy;
  logic [7:0]          r_frame_cnt;
  logic                r_sync_err;
  logic                w_acc;

  function automatic logic [ADDR_W-1:0] brev(input logic [ADDR_W-1:0] v);
    logic [ADDR_W-1:0] r;
    for (int i = 0; i < ADDR_W; i++) r[i] = v[ADDR_W-1-i];
    return (BITREV != 0) ? r : v;
  endfunction

  // Gated by rst_n so the handshake reads 0 while reset is held.
  assign in_ready = rst_n & (r_state != S_FULL);
  assign w_acc    = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_wren      <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_frame_rdy <= 1'b0;
      r_frame_cnt <= '0;
      r_sync_err  <= 1'b0;
    end else begin
      r_wren <= 1'b0;
      // A set further down overrides this clear in the same cycle.
      if (err_clr) r_sync_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_acc && in_sof) begin
            r_wren  <= 1'b1;
            r_addr  <= '0;
            r_data  <= in_data;
            r_cnt   <= ADDR_W'(1);
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_acc) begin
            r_wren <= 1'b1;
            r_data <= in_data;
            if (in_sof) begin
              if (r_cnt != '0) r_sync_err <= 1'b1;
              r_addr <= '0;
              r_cnt  <= ADDR_W'(1);
            end else begin
              r_addr <= brev(r_cnt);
              r_cnt  <= r_cnt + ADDR_W'(1);
              if (&r_cnt) begin
                r_state     <= S_FULL;
                r_frame_rdy <= 1'b1;
                r_frame_cnt <= r_frame_cnt + 8'd1;
              end
            end
          end
        end
        S_FULL: begin
          r_addr <= fft_rd_addr;
          if (fft_ack) begin
            r_state     <= S_IDLE;
            r_frame_rdy <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign frame_rdy   = r_frame_rdy;
  assign regfft_wren = r_wren;
  assign regfft_addr = r_addr;
  assign regfft_data = r_data;
  assign frame_cnt   = r_frame_cnt;
  assign sync_err    = r_sync_err;

endmodule

// File: tb/tb_fft_in_loader.sv
// Bench for fft_in_loader: bit-reversed and natural-order instances share one stimulus stream.
module tb_fft_in_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [37:0] in_data;
  logic        in_sof;
  logic [5:0]  fft_rd_addr;
  logic        fft_ack;
  logic        err_clr;

  logic        rdy1, frdy1, wren1, serr1;
  logic [5:0]  addr1;
  logic [37:0] data1;
  logic [7:0]  fcnt1;
  logic        rdy0, frdy0, wren0, serr0;
  logic [5:0]  addr0;
  logic [37:0] data0;
  logic [7:0]  fcnt0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fft_in_loader #(.ADDR_W(6), .DATA_W(38), .BITREV(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
    .in_ready(rdy1), .fft_rd_addr(fft_rd_addr), .fft_ack(fft_ack), .frame_rdy(frdy1),
    .regfft_wren(wren1), .regfft_addr(addr1), .regfft_data(data1), .frame_cnt(fcnt1),
    .sync_err(serr1), .err_clr(err_clr));

  fft_in_loader #(.ADDR_W(6), .DATA_W(38), .BITREV(0)) dut_nat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
    .in_ready(rdy0), .fft_rd_addr(fft_rd_addr), .fft_ack(fft_ack), .frame_rdy(frdy0),
    .regfft_wren(wren0), .regfft_addr(addr0), .regfft_data(data0), .frame_cnt(fcnt0),
    .sync_err(serr0), .err_clr(err_clr));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int rev6(input int v);
    int r = 0;
    for (int i = 0; i < 6; i++) if ((v / (1 << i)) % 2 == 1) r += 1 << (5 - i);
    return r;
  endfunction

  // Behavioural model: a frame is "collecting" or "handed off"; pos counts samples in the frame.
  bit          m_loading, m_full, m_wren, m_rdy, m_err;
  int          m_pos, m_fcnt, m_a1, m_a0;
  logic [37:0] m_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_loading = 0; m_full = 0; m_wren = 0; m_rdy = 0; m_err = 0;
      m_pos = 0; m_fcnt = 0; m_a1 = 0; m_a0 = 0; m_data = '0;
    end else begin
      m_wren = 0;
      if (err_clr) m_err = 0;
      if (m_full) begin
        m_a1 = fft_rd_addr; m_a0 = fft_rd_addr;
        if (fft_ack) begin m_full = 0; m_rdy = 0; end
      end else if (in_valid) begin
        if (in_sof) begin
          if (m_loading) m_err = 1;
          m_loading = 1;
          m_wren = 1; m_data = in_data; m_a1 = 0; m_a0 = 0; m_pos = 1;
        end else if (m_loading) begin
          m_wren = 1; m_data = in_data; m_a1 = rev6(m_pos); m_a0 = m_pos;
          if (m_pos == 63) begin
            m_loading = 0; m_full = 1; m_rdy = 1; m_fcnt = (m_fcnt + 1) % 256; m_pos = 0;
          end else m_pos++;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready",   rdy1,  rst_n && !m_full);
    chk("in_ready_n", rdy0,  rst_n && !m_full);
    chk("wren",       wren1, m_wren);
    chk("wren_n",     wren0, m_wren);
    chk("addr",       addr1, m_a1);
    chk("addr_n",     addr0, m_a0);
    chk("data",       data1, m_data);
    chk("data_n",     data0, m_data);
    chk("frame_rdy",  frdy1, m_rdy);
    chk("frame_rdy_n",frdy0, m_rdy);
    chk("frame_cnt",  fcnt1, m_fcnt);
    chk("frame_cnt_n",fcnt0, m_fcnt);
    chk("sync_err",   serr1, m_err);
    chk("sync_err_n", serr0, m_err);
  end

  int log1[$];
  int log0[$];
  always @(negedge clk) begin
    if (rst_n && wren1) log1.push_back(int'(addr1));
    if (rst_n && wren0) log0.push_back(int'(addr0));
  end

  task automatic beat(input logic [37:0] d, input logic sof);
    in_valid = 1'b1; in_data = d; in_sof = sof;
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic release_buf();
    fft_ack = 1'b1; idle(1); fft_ack = 1'b0;
  endtask

  initial begin
    logic [63:0] rnd;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sof = 1'b0;
    fft_rd_addr = '0; fft_ack = 1'b0; err_clr = 1'b0;
    idle(3);
    chk("rst_in_ready", rdy1, 0);
    chk("rst_wren", wren1, 0);
    rst_n = 1'b1;
    idle(1);

    // Frame 1: data k at position k, back-to-back.
    log1.delete(); log0.delete();
    for (int k = 0; k < 64; k++) beat(38'(k), k == 0);
    chk("lit_frame_rdy", frdy1, 1);
    chk("lit_frame_cnt", fcnt1, 1);
    chk("lit_in_ready_full", rdy1, 0);
    chk("lit_last_wren", wren1, 1);
    idle(1);
    chk("lit_nwrites", log1.size(), 64);
    if (log1.size() == 64 && log0.size() == 64) begin
      chk("lit_a0", log1[0], 0);  chk("lit_a1", log1[1], 32);
      chk("lit_a2", log1[2], 16); chk("lit_a3", log1[3], 48);
      chk("lit_a4", log1[4], 8);  chk("lit_a63", log1[63], 63);
      chk("lit_nat5", log0[5], 5);
    end

    fft_rd_addr = 6'd5;
    idle(1);
    chk("lit_rd_addr", addr1, 5);
    chk("lit_rd_wren", wren1, 0);
    release_buf();
    chk("lit_ack_rdy", frdy1, 0);
    chk("lit_ack_in_ready", rdy1, 1);
    release_buf();  // ack outside FULL is ignored

    // Beats without sof in IDLE are dropped.
    log1.delete();
    for (int k = 0; k < 3; k++) beat(38'(100 + k), 1'b0);
    idle(1);
    chk("lit_drop_nwrites", log1.size(), 0);
    beat(38'd200, 1'b1);
    idle(1);
    chk("lit_sof_addr", addr1, 0);
    for (int k = 1; k < 20; k++) beat(38'(300 + k), 1'b0);
    beat(38'd400, 1'b1);
    chk("lit_sync_err", serr1, 1);
    chk("lit_restart_addr", addr1, 0);
    for (int k = 1; k < 64; k++) beat(38'(500 + k), 1'b0);
    chk("lit_frame2_rdy", frdy1, 1);
    chk("lit_frame2_cnt", fcnt1, 2);
    err_clr = 1'b1; idle(1); err_clr = 1'b0;
    chk("lit_err_clr", serr1, 0);
    release_buf();

    // Clear coinciding with a new error keeps the flag.
    beat(38'd1, 1'b1);
    for (int k = 1; k < 5; k++) beat(38'(k), 1'b0);
    err_clr = 1'b1; beat(38'd7, 1'b1); err_clr = 1'b0;
    chk("lit_err_priority", serr1, 1);

    // Reset mid-frame discards the partial frame.
    for (int k = 1; k < 30; k++) beat(38'(k), 1'b0);
    rst_n = 1'b0;
    #1;
    chk("lit_rst_frame_cnt", fcnt1, 0);
    chk("lit_rst_wren", wren1, 0);
    chk("lit_rst_in_ready", rdy1, 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    for (int k = 0; k < 64; k++) beat(38'(k + 1000), k == 0);
    chk("lit_after_rst_cnt", fcnt1, 1);
    release_buf();

    // 256 frames with random gaps and data; frame_cnt wraps.
    rst_n = 1'b0; idle(1); rst_n = 1'b1; idle(1);
    for (int f = 0; f < 256; f++) begin
      for (int k = 0; k < 64; k++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        rnd = {$urandom(), $urandom()};
        beat(rnd[37:0], k == 0);
      end
      if (f == 254) chk("lit_cnt_255", fcnt1, 255);
      fft_rd_addr = 6'($urandom_range(0, 63));
      idle($urandom_range(0, 2));
      release_buf();
    end
    chk("lit_cnt_wrap", fcnt1, 0);
    chk("lit_cnt_wrap_n", fcnt0, 0);

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: got no finish expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
